// File: rtl/ram_bist_pkg.sv
// ---------------------------------------------------------------------------
// ram_bist_pkg
// Shared definitions for the RAM BIST controller:
//   - bist_state_e : controller state encoding
//   - RD_LAT       : request-to-data latency seen by the BIST. One cycle for
//                    the registered ram_* outputs, one for the RAM read register.
//   - pat()        : march data pattern for a given address, seed and phase.
// ---------------------------------------------------------------------------
package ram_bist_pkg;

    localparam int RD_LAT = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } bist_state_e;

    // The caller passes zero-extended address/seed and truncates the result
    // to its data width. This handles AW > DW and AW < DW without extra logic.
    // Phase 1 is the bitwise inverse of phase 0, so every stored bit is
    // exercised in both polarities.
    function automatic logic [31:0] pat(input logic [31:0] addr,
                                        input logic [31:0] seed,
                                        input logic        phase);
        logic [31:0] x;
        x = addr ^ seed;
        return phase ? ~x : x;
    endfunction

endpackage

// File: rtl/ram_bist_cmp_pipe.sv
// ---------------------------------------------------------------------------
// ram_bist_cmp_pipe
// Compare pipeline for the RAM BIST. Each read request pushes {addr, expected}.
// The entry leaves the pipe RD_LAT cycles later, in the same cycle that the
// RAM's read data for that address is on i_ram_q. On exit the masked read data
// is compared with the expected value. A mismatch bumps a saturating error
// counter, and the first mismatch of a run is captured.
//
// Ports:
//   i_clk, i_rstn   clock, async active-low reset
//   i_clr           start of run: flush the pipe, clear counter and capture
//   i_push          a read request is issued this cycle
//   i_addr, i_exp   address and masked expected data of that request
//   i_phase         current march phase, recorded with the first failure
//   i_ram_q         RAM read data
//   o_miscmp        exiting entry miscompares this cycle (not yet counted)
//   o_err_cnt       saturating miscompare count
//   o_fail_addr/_data/_phase   first-failure capture
// ---------------------------------------------------------------------------
module ram_bist_cmp_pipe
    import ram_bist_pkg::*;
#(
    parameter int              AW   = 4,
    parameter int              DW   = 4,
    parameter logic [DW-1:0]   MASK = DW'(3)
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_clr,
    input  logic            i_push,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_exp,
    input  logic            i_phase,
    input  logic [DW-1:0]   i_ram_q,
    output logic            o_miscmp,
    output logic [AW+1:0]   o_err_cnt,
    output logic [AW-1:0]   o_fail_addr,
    output logic [DW-1:0]   o_fail_data,
    output logic            o_fail_phase
);

    logic [RD_LAT-1:0]  r_vld;
    logic [AW-1:0]      r_addr [RD_LAT];
    logic [DW-1:0]      r_exp  [RD_LAT];
    logic [AW+1:0]      r_err_cnt;
    logic               r_have_fail;
    logic [AW-1:0]      r_fail_addr;
    logic [DW-1:0]      r_fail_data;
    logic               r_fail_phase;
    logic [DW-1:0]      w_q_masked;
    logic               w_miscmp;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_addr[i] <= '0;
                r_exp[i]  <= '0;
            end
        end else begin
            r_vld[0]  <= i_push & ~i_clr;
            r_addr[0] <= i_addr;
            r_exp[0]  <= i_exp;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1] & ~i_clr;
                r_addr[i] <= r_addr[i-1];
                r_exp[i]  <= r_exp[i-1];
            end
        end
    end

    // i_ram_q is only looked at when the exit stage is valid, so an
    // undriven RAM output while idle cannot reach the counters.
    assign w_q_masked = i_ram_q & MASK;
    assign w_miscmp   = r_vld[RD_LAT-1] && (w_q_masked != r_exp[RD_LAT-1]);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_err_cnt    <= '0;
            r_have_fail  <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
            r_fail_phase <= 1'b0;
        end else if (i_clr) begin
            r_err_cnt    <= '0;
            r_have_fail  <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
            r_fail_phase <= 1'b0;
        end else if (w_miscmp) begin
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + (AW+2)'(1);
            end
            if (!r_have_fail) begin
                r_have_fail  <= 1'b1;
                r_fail_addr  <= r_addr[RD_LAT-1];
                r_fail_data  <= w_q_masked;
                r_fail_phase <= i_phase;
            end
        end
    end

    assign o_miscmp     = w_miscmp;
    assign o_err_cnt    = r_err_cnt;
    assign o_fail_addr  = r_fail_addr;
    assign o_fail_data  = r_fail_data;
    assign o_fail_phase = r_fail_phase;

endmodule

// File: rtl/ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// ram_bist_ctrl
// BIST initiator for a single-port synchronous RAM with a 1-cycle registered
// read. A run consists of two march passes: the seeded pattern, then its
// inverse. Each pass writes every address, then reads every address back and
// compares the data. The block owns the RAM port while o_busy is high. An
// external mux selects between BIST and functional access.
//
// Ports:
//   i_clk, i_rstn        clock, async active-low reset (aborts a run at once)
//   i_start              run request, honoured only in IDLE
//   i_seed               pattern seed, latched when a start is accepted
//   o_busy               run in progress (WRITE..DONE)
//   o_done               one-cycle end-of-run pulse
//   o_pass               result of the last run, held until the next start
//   o_err_cnt            saturating miscompare count
//   o_fail_addr/_data/_phase   first miscompare of the run
//   o_ram_en/_wr/_a/_d   registered RAM request
//   i_ram_q              RAM read data
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; RAM port released
// WRITE | write pat(addr) to every address, one per cycle
// READ  | read every address, one per cycle; expected data enters pipe
// DRAIN | RD_LAT cycles for the last reads to be compared
// DONE  | one cycle: done pulse, pass valid
// ---------------------------------------------------------------------------
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int              AW   = 4,
    parameter int              DW   = 4,
    parameter logic [DW-1:0]   MASK = DW'(3)
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_start,
    input  logic [DW-1:0]   i_seed,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [AW+1:0]   o_err_cnt,
    output logic [AW-1:0]   o_fail_addr,
    output logic [DW-1:0]   o_fail_data,
    output logic            o_fail_phase,
    output logic            o_ram_en,
    output logic            o_ram_wr,
    output logic [AW-1:0]   o_ram_a,
    output logic [DW-1:0]   o_ram_d,
    input  logic [DW-1:0]   i_ram_q
);

    localparam int DCW = $clog2(RD_LAT + 1);

    bist_state_e    r_state;
    bist_state_e    w_state_nxt;

    logic [AW-1:0]  r_addr;
    logic           r_phase;
    logic [DW-1:0]  r_seed;
    logic [DCW-1:0] r_drain_cnt;
    logic           r_pass;
    logic           r_ram_en;
    logic           r_ram_wr;
    logic [AW-1:0]  r_ram_a;
    logic [DW-1:0]  r_ram_d;

    logic           w_accept;
    logic           w_wr_cyc;
    logic           w_rd_cyc;
    logic           w_addr_last;
    logic           w_drain_ld;
    logic           w_phase_flip;
    logic           w_finish;
    logic [DW-1:0]  w_pat;
    logic [DW-1:0]  w_exp;
    logic           w_miscmp;
    logic [AW+1:0]  w_err_cnt;

    assign w_addr_last = (r_addr == '1);
    assign w_pat       = DW'(pat(32'(r_addr), 32'(r_seed), r_phase));
    assign w_exp       = w_pat & MASK;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_wr_cyc     = 1'b0;
        w_rd_cyc     = 1'b0;
        w_drain_ld   = 1'b0;
        w_phase_flip = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                w_wr_cyc = 1'b1;
                if (w_addr_last) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_rd_cyc = 1'b1;
                if (w_addr_last) begin
                    w_drain_ld  = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == '0) begin
                    if (!r_phase) begin
                        w_phase_flip = 1'b1;
                        w_state_nxt  = WRITE;
                    end else begin
                        w_finish     = 1'b1;
                        w_state_nxt  = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_seed      <= '0;
            r_drain_cnt <= '0;
            r_pass      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_seed  <= i_seed;
                r_phase <= 1'b0;
                r_addr  <= '0;
                r_pass  <= 1'b0;
            end
            // The address wraps to 0 after the last location, which is
            // exactly the start address of the next sweep.
            if (w_wr_cyc || w_rd_cyc) begin
                r_addr <= r_addr + AW'(1);
            end
            // Down-counter for the drain time. Loaded with RD_LAT-1 so that
            // DRAIN lasts RD_LAT cycles, then exits on terminal count 0.
            if (w_drain_ld) begin
                r_drain_cnt <= DCW'(RD_LAT - 1);
            end else if (r_drain_cnt != '0) begin
                r_drain_cnt <= r_drain_cnt - DCW'(1);
            end
            if (w_phase_flip) begin
                r_phase <= 1'b1;
                r_addr  <= '0;
            end
            // The last compare retires on the same edge that enters DONE.
            // Its result is therefore not yet in the counter and has to be
            // folded in here.
            if (w_finish) begin
                r_pass <= (w_err_cnt == '0) && !w_miscmp;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ram_en <= 1'b0;
            r_ram_wr <= 1'b0;
            r_ram_a  <= '0;
            r_ram_d  <= '0;
        end else begin
            r_ram_en <= w_wr_cyc | w_rd_cyc;
            r_ram_wr <= w_wr_cyc;
            if (w_wr_cyc || w_rd_cyc) begin
                r_ram_a <= r_addr;
            end
            if (w_wr_cyc) begin
                r_ram_d <= w_pat;
            end
        end
    end

    ram_bist_cmp_pipe #(
        .AW   (AW),
        .DW   (DW),
        .MASK (MASK)
    ) u_cmp (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_clr        (w_accept),
        .i_push       (w_rd_cyc),
        .i_addr       (r_addr),
        .i_exp        (w_exp),
        .i_phase      (r_phase),
        .i_ram_q      (i_ram_q),
        .o_miscmp     (w_miscmp),
        .o_err_cnt    (w_err_cnt),
        .o_fail_addr  (o_fail_addr),
        .o_fail_data  (o_fail_data),
        .o_fail_phase (o_fail_phase)
    );

    assign o_busy    = (r_state != IDLE);
    assign o_done    = (r_state == DONE);
    assign o_pass    = r_pass;
    assign o_err_cnt = w_err_cnt;
    assign o_ram_en  = r_ram_en;
    assign o_ram_wr  = r_ram_wr;
    assign o_ram_a   = r_ram_a;
    assign o_ram_d   = r_ram_d;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_bist_ctrl
// Bench for ram_bist_ctrl with a behavioural single-port RAM. The RAM has
// optional read faults: a stuck bit at one address, or all reads returning 0.
// Expected run results are computed by a march reference model that walks
// addresses and phases with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_ram_bist_ctrl;

    localparam int            AW   = 4;
    localparam int            DW   = 4;
    localparam logic [3:0]    MASK = 4'h3;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic [3:0]     seed = 4'h0;
    logic           busy, done, pass, fail_phase, ram_en, ram_wr;
    logic [5:0]     err_cnt;
    logic [3:0]     fail_addr, fail_data, ram_a, ram_d;
    logic [3:0]     ram_q;

    int n_chk = 0;
    int n_err = 0;

    // fault_mode: 0 none, 1 stuck bit f_bit=f_val at f_addr, 2 all reads 0
    int         fault_mode = 0;
    logic [3:0] f_addr = 4'h0;
    int         f_bit = 0;
    logic       f_val = 1'b0;

    logic [3:0] mem [16];
    logic [3:0] wr_q [$];
    logic [3:0] exp_wr [$];
    logic [3:0] all_exp [$];
    int         m_err;
    logic [3:0] m_faddr, m_fdata;
    logic       m_fph, m_pass;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.AW(AW), .DW(DW), .MASK(MASK)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_seed       (seed),
        .o_busy       (busy),
        .o_done       (done),
        .o_pass       (pass),
        .o_err_cnt    (err_cnt),
        .o_fail_addr  (fail_addr),
        .o_fail_data  (fail_data),
        .o_fail_phase (fail_phase),
        .o_ram_en     (ram_en),
        .o_ram_wr     (ram_wr),
        .o_ram_a      (ram_a),
        .o_ram_d      (ram_d),
        .i_ram_q      (ram_q)
    );

    function automatic logic [3:0] flt(input logic [3:0] a, input logic [3:0] v);
        logic [3:0] r;
        r = v;
        if (fault_mode == 1 && a == f_addr) r[f_bit] = f_val;
        if (fault_mode == 2) r = 4'h0;
        return r & MASK;
    endfunction

    always @(posedge clk) begin
        if (ram_en === 1'b1) begin
            if (ram_wr === 1'b1) mem[ram_a] <= ram_d & MASK;
            else                 ram_q <= flt(ram_a, mem[ram_a]);
        end
    end

    always @(negedge clk) begin
        if (ram_en === 1'b1 && ram_wr === 1'b1) wr_q.push_back(ram_d);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference march: writes pattern, reads back through the fault model.
    task automatic ref_run(input logic [3:0] s);
        logic [3:0] kk, p, e, r;
        bit found;
        m_err = 0; found = 0; m_faddr = 0; m_fdata = 0; m_fph = 0;
        exp_wr.delete();
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < 16; k++) begin
                kk = 4'(k);
                p  = (ph == 1) ? ~(kk ^ s) : (kk ^ s);
                exp_wr.push_back(p);
                e = p & MASK;
                r = flt(kk, e);
                if (r != e) begin
                    if (m_err < 63) m_err++;
                    if (!found) begin
                        found = 1; m_faddr = kk; m_fdata = r; m_fph = 1'(ph);
                    end
                end
            end
        end
        m_pass = (m_err == 0);
    endtask

    task automatic cmp_writes(input string tag, input int n_exp);
        int bad;
        bad = 0;
        chk({tag, "_wr_cnt"}, wr_q.size(), n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i >= wr_q.size() || i >= all_exp.size()) bad++;
            else if (wr_q[i] !== all_exp[i]) bad++;
        end
        chk({tag, "_wr_data_bad"}, bad, 0);
    endtask

    task automatic do_run(input logic [3:0] s, input bit repulse, input string tag);
        int j, nd;
        bit got, busy_ok;
        ref_run(s);
        all_exp = exp_wr;
        @(negedge clk);
        wr_q.delete();
        seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        j = 1; got = 0; busy_ok = 1;
        while (j <= 200) begin
            if (done) begin got = 1; break; end
            if (!busy) busy_ok = 0;
            start = repulse && (j == 20 || j == 50);
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        chk({tag, "_done_cyc"}, j, 69);
        chk({tag, "_busy_run"}, busy_ok, 1);
        chk({tag, "_busy_done"}, busy, 1);
        chk({tag, "_pass"}, pass, m_pass);
        chk({tag, "_err_cnt"}, err_cnt, m_err);
        chk({tag, "_fail_addr"}, fail_addr, m_faddr);
        chk({tag, "_fail_data"}, fail_data, m_fdata);
        chk({tag, "_fail_phase"}, fail_phase, m_fph);
        cmp_writes(tag, 32);
        @(negedge clk);
        chk({tag, "_idle_busy"}, busy, 0);
        nd = 0;
        repeat (5) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk({tag, "_extra_done"}, nd, 0);
        chk({tag, "_pass_held"}, pass, m_pass);
    endtask

    initial begin
        int n;
        logic [3:0] s;
        int dones [$];
        int idles [$];
        logic [3:0] seeds [$];

        rstn = 1'b0;
        #12;
        chk("reset_outs", {busy, done, pass, err_cnt, fail_addr, fail_data, fail_phase,
                           ram_en, ram_wr, ram_a, ram_d}, 0);
        @(negedge clk);
        rstn = 1'b1;

        fault_mode = 0;
        do_run(4'h0, 0, "t1");

        fault_mode = 1; f_addr = 4'h5; f_bit = 1; f_val = 1'b0;
        do_run(4'h0, 0, "t2");
        chk("t2_err_cnt_abs", err_cnt, 1);
        chk("t2_fail_addr_abs", fail_addr, 5);
        chk("t2_fail_phase_abs", fail_phase, 1);

        fault_mode = 2;
        do_run(4'hA, 0, "t3");
        chk("t3_fail_addr_abs", fail_addr, 0);
        chk("t3_fail_data_abs", fail_data, 0);

        fault_mode = 1; f_addr = 4'(($urandom_range(0, 15))); f_bit = $urandom_range(0, 1);
        f_val = 1'($urandom_range(0, 1));
        s = 4'($urandom_range(0, 15));
        do_run(s, 1, "t4a");
        do_run(s, 0, "t4b");

        // Reset in the middle of phase-1 READ.
        fault_mode = 2;
        @(negedge clk);
        seed = 4'($urandom_range(0, 15)); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (54) @(negedge clk);
        chk("t5_busy_pre", busy, 1);
        rstn = 1'b0;
        #1;
        chk("t5_rst_outs", {busy, done, pass, err_cnt, fail_addr, fail_data, fail_phase,
                            ram_en, ram_wr, ram_a, ram_d}, 0);
        @(negedge clk);
        rstn = 1'b1;
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (done || busy) n++;
        end
        chk("t5_quiet", n, 0);
        fault_mode = 0;
        do_run(4'($urandom_range(0, 15)), 0, "t5_rerun");
        chk("t5_rerun_pass", pass, 1);

        // start held high: back-to-back runs, each latching a fresh seed.
        fault_mode = 0;
        @(negedge clk);
        wr_q.delete();
        s = 4'($urandom_range(0, 15));
        seed = s; seeds.push_back(s); start = 1'b1;
        for (int j = 1; j <= 400; j++) begin
            @(negedge clk);
            if (j >= 200) start = 1'b0;
            if (!busy) idles.push_back(j);
            if (done) begin
                dones.push_back(j);
                if (start) begin
                    s = 4'($urandom_range(0, 15));
                    seed = s; seeds.push_back(s);
                end
            end
            if (j > 200 && !busy) break;
        end
        start = 1'b0;
        chk("t6_n_done", dones.size(), 3);
        if (dones.size() >= 1) chk("t6_first_done", dones[0], 69);
        for (int i = 1; i < dones.size(); i++) chk("t6_done_gap", dones[i] - dones[i-1], 70);
        n = 0;
        if (dones.size() >= 2) begin
            foreach (idles[i]) if (idles[i] > dones[0] && idles[i] < dones[dones.size()-1]) n++;
            chk("t6_busy_low", n, dones.size() - 1);
        end
        all_exp.delete();
        foreach (seeds[i]) begin
            ref_run(seeds[i]);
            foreach (exp_wr[k]) all_exp.push_back(exp_wr[k]);
        end
        cmp_writes("t6", 32 * seeds.size());
        chk("t6_pass", pass, 1);

        for (int it = 0; it < 6; it++) begin
            fault_mode = $urandom_range(0, 2);
            f_addr = 4'($urandom_range(0, 15));
            f_bit  = $urandom_range(0, 3);
            f_val  = 1'($urandom_range(0, 1));
            do_run(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
